// File: rtl/wb_collector_if.sv
// wb_collector_if -- bundle of every handshake and data signal of the
// write-back collector, apart from clock and reset.
//
// Ports (slave = collector side):
//   ctrl_valid / ctrl_ready / ctrl_finish : layer start and layer done handshake
//   base_addr_i, row_stride_i             : layer base address and per-row region offset
//   wb_data_i, wb_valid_i, wb_finish_i    : per-row byte stream and end-of-layer pulse
//   guard_i, guard_valid_i                : per-row 6-bit guard stream
//   fm_wr_*                               : per-row packed 32-bit word write ports
//   guard_wr_*                            : per-row guard write ports
interface wb_collector_if #(
    parameter int ROW_NUM = 4,
    parameter int ADDR_W  = 12
);
    logic                        ctrl_valid;
    logic                        ctrl_ready;
    logic                        ctrl_finish;
    logic [ADDR_W-1:0]           base_addr_i;
    logic [ADDR_W-1:0]           row_stride_i;
    logic [ROW_NUM*8-1:0]        wb_data_i;
    logic [ROW_NUM-1:0]          wb_valid_i;
    logic [ROW_NUM-1:0]          wb_finish_i;
    logic [ROW_NUM*6-1:0]        guard_i;
    logic [ROW_NUM-1:0]          guard_valid_i;
    logic [ROW_NUM-1:0]          fm_wr_en_o;
    logic [ROW_NUM*ADDR_W-1:0]   fm_wr_addr_o;
    logic [ROW_NUM*32-1:0]       fm_wr_data_o;
    logic [ROW_NUM*4-1:0]        fm_wr_mask_o;
    logic [ROW_NUM-1:0]          guard_wr_en_o;
    logic [ROW_NUM*ADDR_W-1:0]   guard_wr_addr_o;
    logic [ROW_NUM*6-1:0]        guard_wr_data_o;

    // Producer / controller side
    modport master (
        output ctrl_valid, base_addr_i, row_stride_i,
               wb_data_i, wb_valid_i, wb_finish_i, guard_i, guard_valid_i,
        input  ctrl_ready, ctrl_finish,
               fm_wr_en_o, fm_wr_addr_o, fm_wr_data_o, fm_wr_mask_o,
               guard_wr_en_o, guard_wr_addr_o, guard_wr_data_o
    );

    // Collector side
    modport slave (
        input  ctrl_valid, base_addr_i, row_stride_i,
               wb_data_i, wb_valid_i, wb_finish_i, guard_i, guard_valid_i,
        output ctrl_ready, ctrl_finish,
               fm_wr_en_o, fm_wr_addr_o, fm_wr_data_o, fm_wr_mask_o,
               guard_wr_en_o, guard_wr_addr_o, guard_wr_data_o
    );
endinterface

// File: rtl/wb_collector.sv
// wb_collector -- gathers the per-row byte streams coming out of the PE matrix,
// packs them little-endian into 32-bit words and writes them to per-row
// regions of the feature-map buffer; guard values are written one-for-one to
// the guard buffer. Row r's region starts at base + r*stride (mod 2^ADDR_W).
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wb_collector_if.slave (handshake, streams and write ports)
module wb_collector #(
    parameter int ROW_NUM = 4,
    parameter int ADDR_W  = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_collector_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                           state_q, state_d;
    logic [ADDR_W-1:0]                base_q, base_d;
    logic [ADDR_W-1:0]                stride_q, stride_d;
    logic [ROW_NUM-1:0]               done_q, done_d;
    logic [ROW_NUM-1:0][1:0]          pos_q, pos_d;
    logic [ROW_NUM-1:0][31:0]         pack_q, pack_d;
    logic [ROW_NUM-1:0][ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ROW_NUM-1:0][ADDR_W-1:0]   guard_cnt_q, guard_cnt_d;

    logic [ROW_NUM-1:0]               fm_wr_en_q, fm_wr_en_d;
    logic [ROW_NUM-1:0][ADDR_W-1:0]   fm_wr_addr_q, fm_wr_addr_d;
    logic [ROW_NUM-1:0][31:0]         fm_wr_data_q, fm_wr_data_d;
    logic [ROW_NUM-1:0][3:0]          fm_wr_mask_q, fm_wr_mask_d;
    logic [ROW_NUM-1:0]               guard_wr_en_q, guard_wr_en_d;
    logic [ROW_NUM-1:0][ADDR_W-1:0]   guard_wr_addr_q, guard_wr_addr_d;
    logic [ROW_NUM-1:0][5:0]          guard_wr_data_q, guard_wr_data_d;

    logic [ROW_NUM-1:0][ADDR_W-1:0]   row_base;
    logic [ROW_NUM-1:0][31:0]         word_next;
    logic [ROW_NUM-1:0][2:0]          fill_next;

    // Start address of each row's region; the product is truncated to
    // ADDR_W so regions simply wrap around the buffer.
    always_comb begin
        row_base = '0;
        for (int r = 0; r < ROW_NUM; r++) begin
            row_base[r] = base_q + ADDR_W'(r) * stride_q;
        end
    end

    // Next-state logic: FSM plus the per-row packers. fill_next counts the
    // bytes held for the row including one accepted this cycle, so a finish
    // arriving together with a byte still sees that byte as pending.
    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        stride_d        = stride_q;
        done_d          = done_q;
        pos_d           = pos_q;
        pack_d          = pack_q;
        word_cnt_d      = word_cnt_q;
        guard_cnt_d     = guard_cnt_q;
        fm_wr_en_d      = '0;
        fm_wr_addr_d    = fm_wr_addr_q;
        fm_wr_data_d    = fm_wr_data_q;
        fm_wr_mask_d    = fm_wr_mask_q;
        guard_wr_en_d   = '0;
        guard_wr_addr_d = guard_wr_addr_q;
        guard_wr_data_d = guard_wr_data_q;
        word_next       = '0;
        fill_next       = '0;

        case (state_q)
            IDLE: begin
                if (bus.ctrl_valid) begin
                    base_d      = bus.base_addr_i;
                    stride_d    = bus.row_stride_i;
                    done_d      = '0;
                    pos_d       = '0;
                    pack_d      = '0;
                    word_cnt_d  = '0;
                    guard_cnt_d = '0;
                    state_d     = RUN;
                end
            end

            RUN: begin
                // done_q is only fully set once every row's final flush has
                // already been registered, so DONE never precedes a write.
                if (&done_q) begin
                    state_d = DONE;
                end
                for (int r = 0; r < ROW_NUM; r++) begin
                    word_next[r] = pack_q[r];
                    fill_next[r] = {1'b0, pos_q[r]};
                    if (!done_q[r]) begin
                        if (bus.wb_valid_i[r]) begin
                            word_next[r][{pos_q[r], 3'b000} +: 8] = bus.wb_data_i[8*r +: 8];
                            fill_next[r] = fill_next[r] + 3'd1;
                        end

                        if (fill_next[r] == 3'd4) begin
                            fm_wr_en_d[r]   = 1'b1;
                            fm_wr_addr_d[r] = row_base[r] + word_cnt_q[r];
                            fm_wr_data_d[r] = word_next[r];
                            fm_wr_mask_d[r] = 4'b1111;
                            word_cnt_d[r]   = word_cnt_q[r] + 1'b1;
                            pos_d[r]        = 2'd0;
                            pack_d[r]       = '0;
                        end else if (bus.wb_finish_i[r] && fill_next[r] != 3'd0) begin
                            // Partial flush: unused upper bytes are already
                            // zero because the packer is cleared per word.
                            fm_wr_en_d[r]   = 1'b1;
                            fm_wr_addr_d[r] = row_base[r] + word_cnt_q[r];
                            fm_wr_data_d[r] = word_next[r];
                            fm_wr_mask_d[r] = (4'b0001 << fill_next[r]) - 4'd1;
                            word_cnt_d[r]   = word_cnt_q[r] + 1'b1;
                            pos_d[r]        = 2'd0;
                            pack_d[r]       = '0;
                        end else begin
                            pos_d[r]  = fill_next[r][1:0];
                            pack_d[r] = word_next[r];
                        end

                        if (bus.wb_finish_i[r]) begin
                            done_d[r] = 1'b1;
                            pos_d[r]  = 2'd0;
                            pack_d[r] = '0;
                        end

                        if (bus.guard_valid_i[r]) begin
                            guard_wr_en_d[r]   = 1'b1;
                            guard_wr_addr_d[r] = row_base[r] + guard_cnt_q[r];
                            guard_wr_data_d[r] = bus.guard_i[6*r +: 6];
                            guard_cnt_d[r]     = guard_cnt_q[r] + 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any partially packed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            base_q          <= '0;
            stride_q        <= '0;
            done_q          <= '0;
            pos_q           <= '0;
            pack_q          <= '0;
            word_cnt_q      <= '0;
            guard_cnt_q     <= '0;
            fm_wr_en_q      <= '0;
            fm_wr_addr_q    <= '0;
            fm_wr_data_q    <= '0;
            fm_wr_mask_q    <= '0;
            guard_wr_en_q   <= '0;
            guard_wr_addr_q <= '0;
            guard_wr_data_q <= '0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            stride_q        <= stride_d;
            done_q          <= done_d;
            pos_q           <= pos_d;
            pack_q          <= pack_d;
            word_cnt_q      <= word_cnt_d;
            guard_cnt_q     <= guard_cnt_d;
            fm_wr_en_q      <= fm_wr_en_d;
            fm_wr_addr_q    <= fm_wr_addr_d;
            fm_wr_data_q    <= fm_wr_data_d;
            fm_wr_mask_q    <= fm_wr_mask_d;
            guard_wr_en_q   <= guard_wr_en_d;
            guard_wr_addr_q <= guard_wr_addr_d;
            guard_wr_data_q <= guard_wr_data_d;
        end
    end

    assign bus.ctrl_ready      = (state_q == IDLE);
    assign bus.ctrl_finish     = (state_q == DONE);
    assign bus.fm_wr_en_o      = fm_wr_en_q;
    assign bus.fm_wr_addr_o    = fm_wr_addr_q;
    assign bus.fm_wr_data_o    = fm_wr_data_q;
    assign bus.fm_wr_mask_o    = fm_wr_mask_q;
    assign bus.guard_wr_en_o   = guard_wr_en_q;
    assign bus.guard_wr_addr_o = guard_wr_addr_q;
    assign bus.guard_wr_data_o = guard_wr_data_q;

endmodule

// File: tb/tb_wb_collector.sv
// tb_wb_collector -- directed bench for wb_collector with hand-computed
// expected write addresses, data, masks and handshake timing.
module tb_wb_collector;

    localparam int ROW_NUM = 4;
    localparam int ADDR_W  = 12;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFails;
    logic seen;

    wb_collector_if #(.ROW_NUM(ROW_NUM), .ADDR_W(ADDR_W)) bus ();

    wb_collector #(.ROW_NUM(ROW_NUM), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value with its expected value and counts it
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of stream inputs, then returns the inputs to idle
    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                                 input logic [3:0] finish, input logic [3:0] gValid,
                                 input logic [23:0] gData);
        bus.wb_valid_i    = valid;
        bus.wb_data_i     = data;
        bus.wb_finish_i   = finish;
        bus.guard_valid_i = gValid;
        bus.guard_i       = gData;
        tick();
        bus.wb_valid_i    = '0;
        bus.wb_data_i     = '0;
        bus.wb_finish_i   = '0;
        bus.guard_valid_i = '0;
        bus.guard_i       = '0;
    endtask

    // Starts a layer with the given base and stride
    task automatic startLayer(input logic [11:0] base, input logic [11:0] stride);
        bus.ctrl_valid   = 1'b1;
        bus.base_addr_i  = base;
        bus.row_stride_i = stride;
        tick();
        bus.ctrl_valid   = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        seen    = 1'b0;
        rst_n   = 1'b1;
        bus.ctrl_valid    = 1'b0;
        bus.base_addr_i   = '0;
        bus.row_stride_i  = '0;
        bus.wb_valid_i    = '0;
        bus.wb_data_i     = '0;
        bus.wb_finish_i   = '0;
        bus.guard_valid_i = '0;
        bus.guard_i       = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_ready", bus.ctrl_ready, 1);
        checkOutput("rst_finish", bus.ctrl_finish, 0);
        checkOutput("rst_fm_en", bus.fm_wr_en_o, 0);
        checkOutput("rst_fm_addr", bus.fm_wr_addr_o, 0);
        checkOutput("rst_fm_data", bus.fm_wr_data_o, 0);
        checkOutput("rst_fm_mask", bus.fm_wr_mask_o, 0);
        checkOutput("rst_g_en", bus.guard_wr_en_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Layer 1: base 0x100, stride 0x40
        startLayer(12'h100, 12'h040);
        checkOutput("l1_ready_run", bus.ctrl_ready, 0);
        applyStimulus(4'b0001, 32'h0000_0001, 4'b0000, 4'b0000, 24'h0);
        checkOutput("l1_b1_no_wr", bus.fm_wr_en_o, 0);
        applyStimulus(4'b0001, 32'h0000_0002, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b0001, 32'h0000_0003, 4'b0000, 4'b0000, 24'h0);
        checkOutput("l1_b3_no_wr", bus.fm_wr_en_o, 0);
        applyStimulus(4'b0001, 32'h0000_0004, 4'b0000, 4'b0000, 24'h0);
        checkOutput("l1_r0_en", bus.fm_wr_en_o, 4'b0001);
        checkOutput("l1_r0_addr", bus.fm_wr_addr_o[11:0], 12'h100);
        checkOutput("l1_r0_data", bus.fm_wr_data_o[31:0], 32'h0403_0201);
        checkOutput("l1_r0_mask", bus.fm_wr_mask_o[3:0], 4'b1111);
        tick();
        checkOutput("l1_r0_pulse", bus.fm_wr_en_o, 0);

        // Row 1 partial word flushed by finish
        applyStimulus(4'b0010, 32'h0000_AA00, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b0010, 32'h0000_BB00, 4'b0000, 4'b0000, 24'h0);
        checkOutput("l1_r1_nowr", bus.fm_wr_en_o, 0);
        applyStimulus(4'b0000, 32'h0, 4'b0010, 4'b0000, 24'h0);
        checkOutput("l1_r1_en", bus.fm_wr_en_o, 4'b0010);
        checkOutput("l1_r1_addr", bus.fm_wr_addr_o[23:12], 12'h140);
        checkOutput("l1_r1_data", bus.fm_wr_data_o[63:32], 32'h0000_BBAA);
        checkOutput("l1_r1_mask", bus.fm_wr_mask_o[7:4], 4'b0011);
        // Bytes and a repeated finish on the done row are ignored
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0010, 32'h0000_1100, 4'b0010, 4'b0000, 24'h0);
            checkOutput("l1_r1_done_ign", bus.fm_wr_en_o, 0);
        end
        applyStimulus(4'b0000, 32'h0, 4'b1101, 4'b0000, 24'h0);
        checkOutput("l1_fin_nowr", bus.fm_wr_en_o, 0);
        checkOutput("l1_fin_early", bus.ctrl_finish, 0);
        tick();
        checkOutput("l1_fin_pulse", bus.ctrl_finish, 1);
        checkOutput("l1_fin_ready", bus.ctrl_ready, 0);
        tick();
        checkOutput("l1_fin_drop", bus.ctrl_finish, 0);
        checkOutput("l1_ready_back", bus.ctrl_ready, 1);

        // Inputs while IDLE produce nothing
        applyStimulus(4'b1111, 32'h1234_5678, 4'b0000, 4'b0100, 24'h2A << 12);
        checkOutput("idle_g_en", bus.guard_wr_en_o, 0);
        checkOutput("idle_fm_en", bus.fm_wr_en_o, 0);

        // Layer 2: guards, then all rows finish together with nothing pending
        startLayer(12'h000, 12'h010);
        applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0100, 24'h2A << 12);
        checkOutput("l2_g_en", bus.guard_wr_en_o, 4'b0100);
        checkOutput("l2_g_addr", bus.guard_wr_addr_o[35:24], 12'h020);
        checkOutput("l2_g_data", bus.guard_wr_data_o[17:12], 6'h2A);
        applyStimulus(4'b0000, 32'h0, 4'b0000, 4'b0100, 24'h15 << 12);
        checkOutput("l2_g2_addr", bus.guard_wr_addr_o[35:24], 12'h021);
        checkOutput("l2_g2_data", bus.guard_wr_data_o[17:12], 6'h15);
        applyStimulus(4'b0000, 32'h0, 4'b1111, 4'b0000, 24'h0);
        checkOutput("l2_all_fin_nowr", bus.fm_wr_en_o, 0);
        checkOutput("l2_g_pulse", bus.guard_wr_en_o, 0);
        checkOutput("l2_fin_early", bus.ctrl_finish, 0);
        tick();
        checkOutput("l2_fin_pulse", bus.ctrl_finish, 1);
        checkOutput("l2_fin_nowr", bus.fm_wr_en_o, 0);
        tick();
        checkOutput("l2_ready_back", bus.ctrl_ready, 1);

        // Layer 3: base 0xFFF, address wrap and combined valid/finish cases
        startLayer(12'hFFF, 12'h040);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0001, 32'h10 + i, 4'b0000, 4'b0000, 24'h0);
            if (i == 3) begin
                checkOutput("l3_w0_addr", bus.fm_wr_addr_o[11:0], 12'hFFF);
                checkOutput("l3_w0_data", bus.fm_wr_data_o[31:0], 32'h1312_1110);
            end
        end
        checkOutput("l3_w1_en", bus.fm_wr_en_o, 4'b0001);
        checkOutput("l3_w1_addr", bus.fm_wr_addr_o[11:0], 12'h000);
        checkOutput("l3_w1_data", bus.fm_wr_data_o[31:0], 32'h1716_1514);
        applyStimulus(4'b1100, 32'hA120_0000, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b0100, 32'h0021_0000, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b0100, 32'h0022_0000, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b1100, 32'hA223_0000, 4'b1100, 4'b0000, 24'h0);
        checkOutput("l3_en", bus.fm_wr_en_o, 4'b1100);
        checkOutput("l3_r2_addr", bus.fm_wr_addr_o[35:24], 12'h07F);
        checkOutput("l3_r2_data", bus.fm_wr_data_o[95:64], 32'h2322_2120);
        checkOutput("l3_r2_mask", bus.fm_wr_mask_o[11:8], 4'b1111);
        checkOutput("l3_r3_addr", bus.fm_wr_addr_o[47:36], 12'h0BF);
        checkOutput("l3_r3_data", bus.fm_wr_data_o[127:96], 32'h0000_A2A1);
        checkOutput("l3_r3_mask", bus.fm_wr_mask_o[15:12], 4'b0011);
        tick();
        checkOutput("l3_no_extra", bus.fm_wr_en_o, 0);
        applyStimulus(4'b0000, 32'h0, 4'b0011, 4'b0000, 24'h0);
        checkOutput("l3_fin_nowr", bus.fm_wr_en_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.ctrl_finish) seen = 1'b1;
            else tick();
        end
        checkOutput("l3_finish_seen", seen, 1);
        tick();

        // Layer 4: reset in the middle of a partial word
        startLayer(12'h000, 12'h040);
        applyStimulus(4'b0001, 32'h01, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b0001, 32'h02, 4'b0000, 4'b0000, 24'h0);
        applyStimulus(4'b0001, 32'h03, 4'b0000, 4'b0000, 24'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_en", bus.fm_wr_en_o, 0);
        checkOutput("mid_rst_addr", bus.fm_wr_addr_o, 0);
        checkOutput("mid_rst_data", bus.fm_wr_data_o, 0);
        checkOutput("mid_rst_ready", bus.ctrl_ready, 1);
        tick();
        rst_n = 1'b1;
        applyStimulus(4'b0000, 32'h0, 4'b0001, 4'b0000, 24'h0);
        checkOutput("post_rst_noflush", bus.fm_wr_en_o, 0);
        checkOutput("post_rst_ready", bus.ctrl_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/wb_collector.md
WB_COLLECTOR -- requirements
Module: wb_collector

Interface
REQ-001 SHALL have parameter ROW_NUM, default 4, meaning the number of PE-matrix output rows collected.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning the feature-map and guard buffer address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports ctrl_valid input 1, ctrl_ready output 1, ctrl_finish output 1  layer start/done handshake.
REQ-006 SHALL have ports base_addr_i input ADDR_W and row_stride_i input ADDR_W  layer base address and per-row region offset.
REQ-007 SHALL have ports wb_data_i input ROW_NUM*8, wb_valid_i input ROW_NUM, wb_finish_i input ROW_NUM  per-row write-back byte stream and end-of-layer pulse.
REQ-008 SHALL have ports guard_i input ROW_NUM*6 and guard_valid_i input ROW_NUM  per-row guard stream.
REQ-009 SHALL have ports fm_wr_en_o output ROW_NUM, fm_wr_addr_o output ROW_NUM*ADDR_W, fm_wr_data_o output ROW_NUM*32, fm_wr_mask_o output ROW_NUM*4  per-row packed-word write ports.
REQ-010 SHALL have ports guard_wr_en_o output ROW_NUM, guard_wr_addr_o output ROW_NUM*ADDR_W, guard_wr_data_o output ROW_NUM*6  per-row guard write ports.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; ctrl_ready = 1 only in IDLE.
REQ-012 IDLE: on ctrl_valid, SHALL latch base_addr_i/row_stride_i, clear all byte, word, guard counters and row-done flags, and enter RUN next cycle.
REQ-013 Stream inputs (wb_valid_i, guard_valid_i, wb_finish_i) SHALL be ignored outside RUN; the block has no backpressure and accepts one byte and one guard per row per cycle in RUN.
REQ-014 Per row r, bytes SHALL pack little-endian: byte position p (0..3) goes to data bits [8p+7:8p]; p increments per accepted byte and wraps 3->0.
REQ-015 On accepting the byte at p=3, row r SHALL assert fm_wr_en_o[r] for exactly one cycle in the following cycle with mask 4'b1111, address base + r*stride + word_cnt[r], then increment word_cnt[r].
REQ-016 Address arithmetic SHALL be modulo 2^ADDR_W (wrap, no error).
REQ-017 Each accepted guard SHALL produce guard_wr_en_o[r] one cycle later with guard_wr_addr_o = base + r*stride + guard_cnt[r], data = guard_i row slice; guard_cnt[r] then increments.
REQ-018 On wb_finish_i[r] in RUN with row r not done: set done[r]; if pending bytes exist (including a byte accepted the same cycle), SHALL flush next cycle with mask bits set only for written positions, unused bytes 0; p resets to 0.
REQ-019 Finish with no pending bytes SHALL issue no write; finish on a row already done SHALL be ignored; valid on a done row SHALL be ignored.
REQ-020 Simultaneous valid with p=3 and finish SHALL produce one full-mask write, no extra flush.
REQ-021 When all done flags are set, FSM SHALL enter DONE the next cycle (after last flush is issued); DONE SHALL pulse ctrl_finish for one cycle and return to IDLE.
REQ-022 All write outputs SHALL be registered; enables are single-cycle pulses.

Reset
REQ-023 On rst_n=0 asynchronously: FSM=IDLE, all counters/flags/data 0, ctrl_ready=1 after reset, ctrl_finish=0, all *_wr_en_o=0, all addresses/data/masks=0.
REQ-024 Reset mid-RUN SHALL discard partial words without any write.

Verification
REQ-025 base=0x100, stride=0x40, row0 bytes 01,02,03,04 -> one write row0 addr 0x100 data 0x04030201 mask 1111, one cycle after 4th byte.
REQ-026 row1 bytes AA,BB then finish -> write addr 0x140 data 0x0000BBAA mask 0011; no further row1 writes.
REQ-027 all 4 rows finish in same cycle with no pending bytes -> no writes, ctrl_finish pulses 2 cycles later, ctrl_ready=1 next cycle.
REQ-028 base=0xFFF, row0 8 bytes -> writes at 0xFFF then 0x000 (wrap).
REQ-029 guard 6'h2A valid on row2, base=0, stride=0x10 -> guard write addr 0x020 data 6'h2A next cycle; valid while IDLE -> no write.
REQ-030 rst_n low after 3 bytes in RUN -> outputs 0 immediately, no flush, ctrl_ready=1 after release.
